clmul_xor2_seq: RTL and testbench
=================================

Name: clmul_xor2_seq

Overview:
- Sequential, parametrised successor to the combinational dual-product XOR slices.
- Computes y = clmul(a0,b0) XOR clmul(a1,b1) over GF(2), i.e. the XOR of all bitwise partial products a0[i]&b0[j] and a1[i]&b1[j] at weight i+j.
- Processes DIGIT bits of b per clock, trading latency for area.
- Adds a valid/ready handshake, a per-pair enable mask, an optional XOR-accumulate into the previous result, and a configurable output window.

Parameters:
- W, 8, operand width in bits (all four operands).
- DIGIT, 1, b-bits consumed per RUN cycle. W % DIGIT must be 0; elaboration error otherwise.
- OUT_LSB, 0, lowest product bit presented on y.
- OUT_W, 2*W-1, width of y. OUT_LSB+OUT_W must be <= 2*W-1; elaboration error otherwise.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands and controls valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a0  in  W  pair-0 multiplicand.
- b0  in  W  pair-0 multiplier.
- a1  in  W  pair-1 multiplicand.
- b1  in  W  pair-1 multiplier.
- pair_en  in  2  bit0 enables pair 0, bit1 enables pair 1. A disabled pair contributes zero.
- acc_en  in  1  seed the working product with the accumulator instead of zero.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  OUT_W  bits [OUT_LSB+OUT_W-1:OUT_LSB] of the accumulator.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, in_ready=1, out_valid=0, y=0, accumulator=0, digit counter=0.
  - Reset during RUN or DONE aborts the operation. The result is discarded and the accumulator cleared.
- Internal registers:
  - Operand copies A0, A1 (W bits) and shift registers B0, B1 (W bits).
  - Latched pair_en.
  - Working product P and accumulator ACC (2W-1 bits each).
  - Counter cnt, range 0..W/DIGIT-1.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1. Input inputs are captured when in_valid&in_ready at an edge; the inputs are don't-care afterwards.
  - On capture: P <= acc_en ? ACC : 0, cnt <= 0, go to RUN.
- RUN (in_ready=0, out_valid=0), each cycle:
  - For k in 0..DIGIT-1, shift = cnt*DIGIT+k:
    - P ^= (A0 << shift) if B0[k] and pair_en[0].
    - P ^= (A1 << shift) if B1[k] and pair_en[1].
  - B0 and B1 shift right by DIGIT.
  - No bit may exceed 2W-2 and no product bit may be truncated.
  - When cnt==W/DIGIT-1: ACC <= final P, go to DONE. Otherwise cnt++.
- Latency: out_valid rises exactly W/DIGIT cycles after the accepting edge (8 cycles at W=8, DIGIT=1; 2 cycles at DIGIT=4).
- DONE:
  - out_valid=1 and y=ACC window. y is stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: go to IDLE.
  - in_ready is low during DONE, so there is no capture on the handshake edge. The next capture is possible one cycle later.
  - The minimum period between consecutive captures is W/DIGIT+2 cycles.
- y output:
  - y is registered and continuously reflects the ACC window in every state, including IDLE after a handshake.
  - ACC persists across operations until rst or a non-accumulating operation overwrites it.
- Corner cases:
  - pair_en=2'b00 gives y = acc_en ? previous ACC : 0.
  - in_valid while not IDLE is ignored; the source must hold in_valid.
  - Zero operands give a zero contribution.
  - out_ready asserted while out_valid=0 has no effect.

Test Plan:
- W=8, DIGIT=1, pair_en=3, acc_en=0, a0=0x03, b0=0x03, a1=0x02, b1=0x01 -> out_valid rises 8 cycles after accept; y=0x0007 (0x05 ^ 0x02).
- a0=0xFF, b0=0xFF, a1=0x00, b1=0x00, acc_en=0 -> y=0x5555. Repeat with DIGIT=4 -> same y, out_valid 2 cycles after accept.
- Accumulate: op1 a0=b0=0x03, pair_en=1 -> y=0x0005. Then op2 a1=0x02, b1=0x01, pair_en=2, acc_en=1 -> y=0x0007. Then op3 same as op2 with acc_en=0 -> y=0x0002.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> y and out_valid constant, in_ready=0, a second in_valid is not captured. Release -> in_ready=1 on the next cycle, then the second operation is captured.
- Reset mid-RUN: assert rst at RUN cycle 3 of an operation with a0=b0=0xFF -> next cycle state IDLE, out_valid=0, y=0. A following acc_en=1 operation with a0=b0=0x03 gives y=0x0005.
- Window: OUT_LSB=4, OUT_W=8, a0=b0=0xFF, pair_en=1 -> y=0x55. pair_en=0, acc_en=0 -> y=0x00.

Source files
------------

// File: rtl/clmul_xor2_seq.sv
// Sequential dual carry-less multiplier: y = clmul(a0,b0) ^ clmul(a1,b1), DIGIT multiplier bits per cycle,
// with valid/ready handshakes, per-pair enables, optional XOR-accumulate and a selectable output window.
module clmul_xor2_seq #(
    parameter int W       = 8,
    parameter int DIGIT   = 1,
    parameter int OUT_LSB = 0,
    parameter int OUT_W   = 2*W-1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a0,
    input  logic [W-1:0]       b0,
    input  logic [W-1:0]       a1,
    input  logic [W-1:0]       b1,
    input  logic [1:0]         pair_en,
    input  logic               acc_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   y
);

    localparam int PW   = 2*W-1;
    localparam int NDIG = W / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (DIGIT < 1 || (W % DIGIT) != 0) begin : g_badDigit
            $error("clmul_xor2_seq: DIGIT must be >= 1 and divide W");
        end
        if (OUT_LSB < 0 || OUT_W < 1 || (OUT_LSB + OUT_W) > PW) begin : g_badWindow
            $error("clmul_xor2_seq: output window exceeds the 2*W-1 bit product");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [W-1:0]    r_a0;
    logic [W-1:0]    r_a1;
    logic [W-1:0]    r_b0;
    logic [W-1:0]    r_b1;
    logic [1:0]      r_pairEn;
    logic [PW-1:0]   r_prod;
    logic [PW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   w_prodNext;
    logic            w_lastDigit;

    assign w_lastDigit = (r_cnt == CW'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (w_lastDigit) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // One digit of both products; the low DIGIT bits of the shifted B registers select this cycle's terms.
    always_comb begin
        w_prodNext = r_prod;
        for (int k = 0; k < DIGIT; k++) begin
            if (r_b0[k] && r_pairEn[0]) begin
                w_prodNext = w_prodNext ^ (PW'(r_a0) << (int'(r_cnt) * DIGIT + k));
            end
            if (r_b1[k] && r_pairEn[1]) begin
                w_prodNext = w_prodNext ^ (PW'(r_a1) << (int'(r_cnt) * DIGIT + k));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a0     <= '0;
            r_a1     <= '0;
            r_b0     <= '0;
            r_b1     <= '0;
            r_pairEn <= '0;
            r_prod   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a0     <= a0;
                        r_a1     <= a1;
                        r_b0     <= b0;
                        r_b1     <= b1;
                        r_pairEn <= pair_en;
                        r_prod   <= acc_en ? r_acc : '0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_prod <= w_prodNext;
                    r_b0   <= r_b0 >> DIGIT;
                    r_b1   <= r_b1 >> DIGIT;
                    if (w_lastDigit) begin
                        r_acc <= w_prodNext;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The accumulator only changes on the last RUN edge, so y holds steady through DONE and IDLE.
    assign y = r_acc[OUT_LSB +: OUT_W];

endmodule

// File: tb/tb_clmul_xor2_seq.sv
// Directed bench for clmul_xor2_seq: bit-serial, 4-bit-digit and windowed instances share one clock and operand bus.
module tb_clmul_xor2_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  inValid;
    logic [2:0]  outReady;
    logic [2:0]  inReady;
    logic [2:0]  outValid;
    logic [7:0]  a0;
    logic [7:0]  b0;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic [1:0]  pairEn;
    logic        accEn;
    logic [14:0] y0;
    logic [14:0] y1;
    logic [7:0]  y2;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    clmul_xor2_seq #(.W(8), .DIGIT(1), .OUT_LSB(0), .OUT_W(15)) dutSerial (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .pair_en(pairEn), .acc_en(accEn),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .y(y0)
    );

    clmul_xor2_seq #(.W(8), .DIGIT(4), .OUT_LSB(0), .OUT_W(15)) dutDigit4 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .pair_en(pairEn), .acc_en(accEn),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .y(y1)
    );

    clmul_xor2_seq #(.W(8), .DIGIT(1), .OUT_LSB(4), .OUT_W(8)) dutWindow (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .pair_en(pairEn), .acc_en(accEn),
        .out_valid(outValid[2]), .out_ready(outReady[2]), .y(y2)
    );

    // Present one operation to instance sel for a single accepting edge, then scramble the bus.
    task automatic startOp(input int sel, input logic [7:0] opA0, input logic [7:0] opB0,
                           input logic [7:0] opA1, input logic [7:0] opB1,
                           input logic [1:0] pe, input logic ae);
        @(negedge clk);
        a0 = opA0; b0 = opB0; a1 = opA1; b1 = opB1; pairEn = pe; accEn = ae;
        inValid[sel] = 1'b1;
        @(posedge clk);
        #1;
        inValid[sel] = 1'b0;
        a0 = 8'hA5; b0 = 8'h5A; a1 = 8'h3C; b1 = 8'hC3; pairEn = 2'b11; accEn = 1'b1;
    endtask

    task automatic waitOut(input int sel, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (outValid[sel] !== 1'b1 && cycles < 40);
    endtask

    task automatic finishOp(input int sel);
        @(negedge clk);
        outReady[sel] = 1'b1;
        @(posedge clk);
        #1;
        outReady[sel] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (inReady !== 3'b111) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=111", inReady); end
        total++; if (outValid !== 3'b000) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=000", outValid); end
        total++; if (y0 !== 15'h0) begin bad++; $display("[TB] FAIL reset_y0 got=%h want=0", y0); end
        total++; if (y1 !== 15'h0) begin bad++; $display("[TB] FAIL reset_y1 got=%h want=0", y1); end
        total++; if (y2 !== 8'h0) begin bad++; $display("[TB] FAIL reset_y2 got=%h want=0", y2); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        startOp(0, 8'h03, 8'h03, 8'h02, 8'h01, 2'b11, 1'b0);
        waitOut(0, lat);
        total++; if (lat != 8) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=8", lat); end
        total++; if (y0 !== 15'h0007) begin bad++; $display("[TB] FAIL basic_y got=%h want=0007", y0); end
        finishOp(0);
        @(negedge clk);
        total++; if (outValid[0] !== 1'b0 || inReady[0] !== 1'b1) begin
            bad++; $display("[TB] FAIL basic_idle got ov=%b ir=%b want ov=0 ir=1", outValid[0], inReady[0]);
        end
        total++; if (y0 !== 15'h0007) begin bad++; $display("[TB] FAIL basic_y_hold got=%h want=0007", y0); end
    endtask

    task automatic test_all_ones;
        int lat;
        startOp(0, 8'hFF, 8'hFF, 8'h00, 8'h00, 2'b11, 1'b0);
        waitOut(0, lat);
        total++; if (lat != 8) begin bad++; $display("[TB] FAIL ones_latency got=%0d want=8", lat); end
        total++; if (y0 !== 15'h5555) begin bad++; $display("[TB] FAIL ones_y got=%h want=5555", y0); end
        finishOp(0);
        startOp(1, 8'hFF, 8'hFF, 8'h00, 8'h00, 2'b11, 1'b0);
        waitOut(1, lat);
        total++; if (lat != 2) begin bad++; $display("[TB] FAIL digit4_latency got=%0d want=2", lat); end
        total++; if (y1 !== 15'h5555) begin bad++; $display("[TB] FAIL digit4_y got=%h want=5555", y1); end
        finishOp(1);
    endtask

    task automatic test_accumulate;
        logic [7:0]  tA0 [5] = '{8'h03, 8'h00, 8'h00, 8'hFF, 8'hFF};
        logic [7:0]  tB0 [5] = '{8'h03, 8'h00, 8'h00, 8'hFF, 8'hFF};
        logic [7:0]  tA1 [5] = '{8'h00, 8'h02, 8'h02, 8'hFF, 8'hFF};
        logic [7:0]  tB1 [5] = '{8'h00, 8'h01, 8'h01, 8'hFF, 8'hFF};
        logic [1:0]  tPe [5] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
        logic        tAe [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [14:0] tY  [5] = '{15'h0005, 15'h0007, 15'h0002, 15'h0002, 15'h0000};
        int lat;
        for (int i = 0; i < 5; i++) begin
            startOp(0, tA0[i], tB0[i], tA1[i], tB1[i], tPe[i], tAe[i]);
            waitOut(0, lat);
            total++; if (lat != 8) begin bad++; $display("[TB] FAIL acc%0d_latency got=%0d want=8", i, lat); end
            total++; if (y0 !== tY[i]) begin bad++; $display("[TB] FAIL acc%0d_y got=%h want=%h", i, y0, tY[i]); end
            finishOp(0);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        startOp(0, 8'h03, 8'h03, 8'h00, 8'h00, 2'b01, 1'b0);
        waitOut(0, lat);
        total++; if (lat != 8 || y0 !== 15'h0005) begin
            bad++; $display("[TB] FAIL b2b_first got lat=%0d y=%h want lat=8 y=0005", lat, y0);
        end
        a0 = 8'hFF; b0 = 8'hFF; a1 = 8'h00; b1 = 8'h00; pairEn = 2'b01; accEn = 1'b0;
        inValid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++; if (outValid[0] !== 1'b1 || inReady[0] !== 1'b0 || y0 !== 15'h0005) begin
                bad++; $display("[TB] FAIL b2b_stall%0d got ov=%b ir=%b y=%h want ov=1 ir=0 y=0005",
                                i, outValid[0], inReady[0], y0);
            end
        end
        outReady[0] = 1'b1;
        @(posedge clk);
        #1;
        outReady[0] = 1'b0;
        @(negedge clk);
        total++; if (inReady[0] !== 1'b1 || outValid[0] !== 1'b0 || y0 !== 15'h0005) begin
            bad++; $display("[TB] FAIL b2b_release got ir=%b ov=%b y=%h want ir=1 ov=0 y=0005",
                            inReady[0], outValid[0], y0);
        end
        @(posedge clk);
        #1;
        inValid[0] = 1'b0;
        @(negedge clk);
        total++; if (inReady[0] !== 1'b0) begin bad++; $display("[TB] FAIL b2b_capture got ir=%b want=0", inReady[0]); end
        waitOut(0, lat);
        total++; if (lat != 8) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=8", lat); end
        total++; if (y0 !== 15'h5555) begin bad++; $display("[TB] FAIL b2b_y got=%h want=5555", y0); end
        finishOp(0);
    endtask

    task automatic test_reset_mid_run;
        int lat;
        startOp(0, 8'hFF, 8'hFF, 8'h00, 8'h00, 2'b01, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (inReady[0] !== 1'b1 || outValid[0] !== 1'b0) begin
            bad++; $display("[TB] FAIL abort_state got ir=%b ov=%b want ir=1 ov=0", inReady[0], outValid[0]);
        end
        total++; if (y0 !== 15'h0) begin bad++; $display("[TB] FAIL abort_y got=%h want=0", y0); end
        startOp(0, 8'h03, 8'h03, 8'h00, 8'h00, 2'b01, 1'b1);
        waitOut(0, lat);
        total++; if (lat != 8) begin bad++; $display("[TB] FAIL abort_next_latency got=%0d want=8", lat); end
        total++; if (y0 !== 15'h0005) begin bad++; $display("[TB] FAIL abort_next_y got=%h want=0005", y0); end
        finishOp(0);
    endtask

    task automatic test_window;
        int lat;
        startOp(2, 8'hFF, 8'hFF, 8'h00, 8'h00, 2'b01, 1'b0);
        waitOut(2, lat);
        total++; if (lat != 8) begin bad++; $display("[TB] FAIL window_latency got=%0d want=8", lat); end
        total++; if (y2 !== 8'h55) begin bad++; $display("[TB] FAIL window_y got=%h want=55", y2); end
        finishOp(2);
        startOp(2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'b00, 1'b0);
        waitOut(2, lat);
        total++; if (y2 !== 8'h00) begin bad++; $display("[TB] FAIL window_off_y got=%h want=00", y2); end
        finishOp(2);
    endtask

    initial begin
        rst = 1'b1;
        inValid = '0;
        outReady = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; pairEn = '0; accEn = 1'b0;
        test_reset();
        test_basic();
        test_all_ones();
        test_accumulate();
        test_back_to_back();
        test_reset_mid_run();
        test_window();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

endmodule
